// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: shifts a word left one bit per cycle until normalized and reports the shift count.
// Define NORM_SIGNED_EN to add the sign_mode port (count redundant sign bits instead of leading zeros).
module seq_normalizer #(
    parameter  int DATA_WIDTH = 8,
    localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef NORM_SIGNED_EN
    input  logic                  sign_mode,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_WIDTH-1:0]  shamt,
    output logic                  zero
);

    // state | meaning
    // IDLE  | waiting for in_valid; in_ready high
    // SHIFT | shifting the work register until normalized
    // DONE  | result presented; waiting for out_ready
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] work, work_nxt, dout_nxt;
    logic [CNT_WIDTH-1:0]  count, count_nxt, shamt_nxt;
    logic                  zero_nxt;
    logic                  smode;
    logic                  stop;

`ifdef NORM_SIGNED_EN
    // Mode is captured on the accepting edge so it stays fixed for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            smode <= 1'b0;
        else if (state == IDLE && in_valid)
            smode <= sign_mode;
    end
`else
    assign smode = 1'b0;
`endif

    assign stop = smode ? ((work[DATA_WIDTH-1] ^ work[DATA_WIDTH-2]) || (count == CNT_MAX))
                        : work[DATA_WIDTH-1];

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
            dout  <= '0;
            shamt <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            count <= count_nxt;
            dout  <= dout_nxt;
            shamt <= shamt_nxt;
            zero  <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        count_nxt = count;
        dout_nxt  = dout;
        shamt_nxt = shamt;
        zero_nxt  = zero;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (din == '0) begin
                        dout_nxt  = '0;
                        shamt_nxt = '0;
                        zero_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        work_nxt  = din;
                        count_nxt = '0;
                        zero_nxt  = 1'b0;
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (stop) begin
                    dout_nxt  = work;
                    shamt_nxt = count;
                    state_nxt = DONE;
                end else begin
                    work_nxt  = {work[DATA_WIDTH-2:0], 1'b0};
                    count_nxt = count + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/seq_normalizer.md
Name: seq_normalizer

Overview:
Iterative left-normalizer; the inverse of the team's barrel shifter. The barrel shifter applies a given shift amount; this block takes a data word and finds the shift amount. It counts leading zeros by shifting the word left one bit per cycle until the MSB is 1. It returns the normalized word and the shift count that, fed back to the barrel shifter's left-shift path, reproduces the result. Sits in front of the shifter/ALU datapath; valid/ready on both sides.

Parameters:
DATA_WIDTH, 8, data word width; legal range >= 2.
CNT_WIDTH, $clog2(DATA_WIDTH), shift-count width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  din is valid
in_ready  output  1  block can accept; (state==IDLE) && !rst
din  input  DATA_WIDTH  word to normalize
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
dout  output  DATA_WIDTH  normalized word (registered)
shamt  output  CNT_WIDTH  number of left shifts applied (registered)
zero  output  1  input word was all zeros (registered)

Behaviour:
- Reset (async, rst=1): state=IDLE; work register, count, dout, shamt, zero, out_valid all 0; in_ready forced to 0 while rst is high. Reset in any state, including mid-SHIFT, abandons the operation immediately with no output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on an edge with in_valid=1:
  - din==0: go to DONE; dout=0, shamt=0, zero=1.
  - Otherwise: load din into the work register, clear the count and zero, go to SHIFT.
  - Nothing is accepted in any other state.
- SHIFT, evaluated each edge:
  - If work[DATA_WIDTH-1]==1: go to DONE; dout=work, shamt=count.
  - Else: work = work<<1 with 0 shifted in, count = count+1.
  - The count cannot exceed DATA_WIDTH-1, because a nonzero word reaches MSB=1 within DATA_WIDTH-1 shifts.
- DONE:
  - out_valid=1; dout, shamt and zero are held stable until out_ready=1.
  - On the edge with out_valid && out_ready: go to IDLE, out_valid=0. dout, shamt and zero keep their last values.
  - in_ready goes to 1 in the following cycle. There is no same-cycle handoff from DONE to the next accept.
- Latency: let L = leading-zero count of din, and let edge 0 be the accepting edge.
  - Nonzero din: out_valid is high after edge L+1.
  - Zero din: out_valid is high after edge 0.
- Throughput: one word per (latency + 1 handshake cycle) minimum.
- in_valid and din are ignored outside IDLE. out_ready is ignored outside DONE.

Optional Feature:
Macro NORM_SIGNED_EN.
- Defined: adds input port sign_mode (1 bit), sampled on the accepting edge and held for the whole operation. With sign_mode=1, the block counts redundant sign bits instead of leading zeros:
  - SHIFT terminates when work[DATA_WIDTH-1] != work[DATA_WIDTH-2], or when count == DATA_WIDTH-1.
  - din==0 still takes the zero path.
  - All-ones input yields shamt=DATA_WIDTH-1 and dout = MSB set, rest 0.
  - With sign_mode=0, behaviour is identical to the unsigned mode.
- Undefined: sign_mode port absent; unsigned leading-zero mode only.

Test Plan:
- din=0x80, out_ready=1 -> out_valid after edge 1; dout=0x80, shamt=0, zero=0; in_ready high again the cycle after the handshake.
- din=0x01 -> out_valid after edge 8; dout=0x80, shamt=7. din=0x13 -> out_valid after edge 4; dout=0x98, shamt=3.
- din=0x00 -> out_valid after edge 0; zero=1, dout=0x00, shamt=0.
- Backpressure: din=0x13, out_ready held 0 for 5 cycles in DONE -> out_valid, dout=0x98 and shamt=3 stable throughout; in_valid pulses during those cycles are not accepted.
- Reset: rst asserted 2 cycles into a din=0x01 operation -> outputs cleared asynchronously, state IDLE. Then din=0x40 -> dout=0x80, shamt=1.
- NORM_SIGNED_EN, sign_mode=1:
  - din=0xF3 -> dout=0x98, shamt=3.
  - din=0xFF -> dout=0x80, shamt=7.
  - din=0x13 -> dout=0x4C, shamt=2.
